// File: rtl/gpio_led_pkg.sv
// Shared constants for the GPIO/LED output peripheral: register map and
// default field layout of the packed CTRL word.
package gpio_led_pkg;

    // Register select values on the peripheral bus
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLR   = 2'd2;
    localparam logic [1:0] ADDR_BLINK = 2'd3;

    // Default field widths; CTRL packs {gpio, led, counter_set} into 32 bits
    localparam int DEF_LED_W  = 8;
    localparam int DEF_CSET_W = 2;
    localparam int DEF_GP_W   = 22;
    localparam int DEF_DIV_W  = 24;

    // Default CTRL field offsets (counter_set sits in the LSBs)
    localparam int DEF_CSET_LSB = 0;
    localparam int DEF_LED_LSB  = DEF_CSET_W;
    localparam int DEF_GP_LSB   = DEF_CSET_W + DEF_LED_W;

endpackage

// File: rtl/gpio_led_ctrl_if.sv
// CPU peripheral bus as seen by the GPIO/LED block: one write strobe,
// a register select, write data and combinational read data.
interface gpio_led_ctrl_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_led_ctrl_blink_timer.sv
// Blink prescaler: counts 0..period, toggling phase on each wrap, so each
// phase lasts period+1 cycles. A zero period parks the engine at phase 0.
module blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] period,
    input  logic             restart,
    output logic             phase,
    output logic [DIV_W-1:0] count
);

    logic [DIV_W-1:0] count_d, count_q;
    logic             phase_d, phase_q;

    // Next prescaler/phase: restart wins, then idle on zero period, then count/wrap
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (restart || period == '0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q == period) begin
            count_d = '0;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Timer state updates on the falling edge with synchronous reset
    always_ff @(negedge clk) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign count = count_q;

endmodule

// File: rtl/gpio_led_ctrl.sv
// Memory-mapped GPIO/LED output register with atomic LED set/clear and a
// hardware blink overlay. Widths must satisfy CSET_W+LED_W+GP_W == 32 and
// LED_W+DIV_W <= 32 so every field fits in one bus word.
module gpio_led_ctrl
    import gpio_led_pkg::*;
#(
    parameter int               LED_W   = DEF_LED_W,
    parameter int               CSET_W  = DEF_CSET_W,
    parameter int               GP_W    = DEF_GP_W,
    parameter int               DIV_W   = DEF_DIV_W,
    parameter logic [LED_W-1:0] RST_LED = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    gpio_led_ctrl_if.slave    bus,
    output logic [LED_W-1:0]  led_out,
    output logic [CSET_W-1:0] counter_set,
    output logic [GP_W-1:0]   gpio_out,
    output logic              blink_phase
);

    localparam int LED_LSB = CSET_W;
    localparam int GP_LSB  = CSET_W + LED_W;

    logic [LED_W-1:0]  led_base_d, led_base_q;
    logic [CSET_W-1:0] cset_d, cset_q;
    logic [GP_W-1:0]   gpio_d, gpio_q;
    logic [LED_W-1:0]  blink_mask_d, blink_mask_q;
    logic [DIV_W-1:0]  blink_period_d, blink_period_q;

    logic [DIV_W-1:0]  prescaler;
    logic              phase;
    logic              blink_wr;

    // A BLINK write restarts the timer on the same edge it loads the period
    assign blink_wr = bus.we && (bus.addr == ADDR_BLINK);

    // Register file next-state: decode the write and update only the target fields
    always_comb begin
        led_base_d     = led_base_q;
        cset_d         = cset_q;
        gpio_d         = gpio_q;
        blink_mask_d   = blink_mask_q;
        blink_period_d = blink_period_q;
        if (bus.we) begin
            case (bus.addr)
                ADDR_CTRL: begin
                    cset_d     = bus.wdata[CSET_W-1:0];
                    led_base_d = bus.wdata[LED_LSB +: LED_W];
                    gpio_d     = bus.wdata[GP_LSB +: GP_W];
                end
                ADDR_SET: led_base_d = led_base_q | bus.wdata[LED_W-1:0];
                ADDR_CLR: led_base_d = led_base_q & ~bus.wdata[LED_W-1:0];
                default: begin
                    blink_mask_d   = bus.wdata[LED_W-1:0];
                    blink_period_d = bus.wdata[LED_W +: DIV_W];
                end
            endcase
        end
    end

    // Register file state, falling edge, reset overrides any write
    always_ff @(negedge clk) begin
        if (rst) begin
            led_base_q     <= RST_LED;
            cset_q         <= '0;
            gpio_q         <= '0;
            blink_mask_q   <= '0;
            blink_period_q <= '0;
        end else begin
            led_base_q     <= led_base_d;
            cset_q         <= cset_d;
            gpio_q         <= gpio_d;
            blink_mask_q   <= blink_mask_d;
            blink_period_q <= blink_period_d;
        end
    end

    blink_timer #(.DIV_W(DIV_W)) u_blink_timer (
        .clk     (clk),
        .rst     (rst),
        .period  (blink_period_q),
        .restart (blink_wr),
        .phase   (phase),
        .count   (prescaler)
    );

    // Blinking LEDs invert their base value while phase is high
    assign led_out     = led_base_q ^ (blink_mask_q & {LED_W{phase}});
    assign counter_set = cset_q;
    assign gpio_out    = gpio_q;
    assign blink_phase = phase;

    // Combinational readback, unused high bits zero
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_CTRL:  bus.rdata = {gpio_q, led_base_q, cset_q};
            ADDR_SET:   bus.rdata[LED_W-1:0] = led_out;
            ADDR_CLR:   bus.rdata[DIV_W:0] = {phase, prescaler};
            default:    bus.rdata[LED_W+DIV_W-1:0] = {blink_period_q, blink_mask_q};
        endcase
    end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Directed self-checking bench for gpio_led_ctrl with default parameters.
// Inputs change 1ns after the falling edge; outputs are checked there too.
module tb_gpio_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  led_out;
    logic [1:0]  counter_set;
    logic [21:0] gpio_out;
    logic        blink_phase;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_led_ctrl_if bus ();

    gpio_led_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .led_out     (led_out),
        .counter_set (counter_set),
        .gpio_out    (gpio_out),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        bus.we = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        bus.we = 1'b0;
        rst    = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        n_checks++;
        if (led_out !== 8'hAA) begin n_fail++; $display("FAIL reset_led: got %h want %h", led_out, 8'hAA); end
        n_checks++;
        if (counter_set !== 2'b00) begin n_fail++; $display("FAIL reset_cset: got %h want 0", counter_set); end
        n_checks++;
        if (gpio_out !== 22'h0) begin n_fail++; $display("FAIL reset_gpio: got %h want 0", gpio_out); end
        n_checks++;
        if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL reset_phase: got %b want 0", blink_phase); end
        rd(2'd0, r);
        n_checks++;
        if (r !== 32'h0000_02A8) begin n_fail++; $display("FAIL reset_rd0: got %h want %h", r, 32'h0000_02A8); end
        rd(2'd3, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_rd3: got %h want 0", r); end
    endtask

    task automatic test_ctrl();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h0000_0F3D);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (counter_set !== 2'b01) begin n_fail++; $display("FAIL ctrl_cset[%0d]: got %h want 1", i, counter_set); end
            n_checks++;
            if (led_out !== 8'hCF) begin n_fail++; $display("FAIL ctrl_led[%0d]: got %h want CF", i, led_out); end
            n_checks++;
            if (gpio_out !== 22'h3) begin n_fail++; $display("FAIL ctrl_gpio[%0d]: got %h want 3", i, gpio_out); end
            idle(1);
        end
        rd(2'd0, r);
        n_checks++;
        if (r !== 32'h0000_0F3D) begin n_fail++; $display("FAIL ctrl_rd0: got %h want %h", r, 32'h0000_0F3D); end
    endtask

    task automatic test_set_clr();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h0000_1EAB);   // gpio=7, led=AA, cset=3
        wr(2'd1, 32'hFFFF_FF01);   // only low LED_W bits matter
        n_checks++;
        if (led_out !== 8'hAB) begin n_fail++; $display("FAIL set_led: got %h want AB", led_out); end
        wr(2'd2, 32'h0000_000A);
        n_checks++;
        if (led_out !== 8'hA1) begin n_fail++; $display("FAIL clr_led: got %h want A1", led_out); end
        n_checks++;
        if (gpio_out !== 22'h7) begin n_fail++; $display("FAIL setclr_gpio: got %h want 7", gpio_out); end
        n_checks++;
        if (counter_set !== 2'b11) begin n_fail++; $display("FAIL setclr_cset: got %h want 3", counter_set); end
        rd(2'd1, r);
        n_checks++;
        if (r !== 32'h0000_00A1) begin n_fail++; $display("FAIL setclr_rd1: got %h want A1", r); end
        rd(2'd3, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL setclr_rd3: got %h want 0", r); end
    endtask

    // Blink then mid-blink SET and period rewrite, continuing one sequence
    task automatic test_blink();
        logic [31:0] r;
        logic        ph;
        do_reset();
        wr(2'd3, 32'h0000_030F);
        rd(2'd3, r);
        n_checks++;
        if (r !== 32'h0000_030F) begin n_fail++; $display("FAIL blink_rd3: got %h want %h", r, 32'h0000_030F); end
        n_checks++;
        if (led_out !== 8'hAA) begin n_fail++; $display("FAIL blink_led0: got %h want AA", led_out); end
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            ph = ((i / 4) % 2) == 1;
            n_checks++;
            if (led_out !== (ph ? 8'hA5 : 8'hAA)) begin
                n_fail++; $display("FAIL blink_led[%0d]: got %h want %h", i, led_out, ph ? 8'hA5 : 8'hAA);
            end
            rd(2'd2, r);
            n_checks++;
            if (r !== {7'd0, ph, 24'(i % 4)}) begin
                n_fail++; $display("FAIL blink_rd2[%0d]: got %h want %h", i, r, {7'd0, ph, 24'(i % 4)});
            end
        end
        // Phase is 1 here with prescaler 0; SET must not disturb the timer
        wr(2'd1, 32'h0000_0040);
        n_checks++;
        if (led_out !== 8'hE5) begin n_fail++; $display("FAIL midset_led: got %h want E5", led_out); end
        rd(2'd2, r);
        n_checks++;
        if (r !== 32'h0100_0001) begin n_fail++; $display("FAIL midset_rd2: got %h want 01000001", r); end
        wr(2'd3, 32'h0000_000F);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (led_out !== 8'hEA || blink_phase !== 1'b0) begin
                n_fail++; $display("FAIL stop_led[%0d]: got %h/%b want EA/0", i, led_out, blink_phase);
            end
            idle(1);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        do_reset();
        wr(2'd3, 32'h0000_03FF);
        idle(4);
        n_checks++;
        if (led_out !== 8'h55) begin n_fail++; $display("FAIL midrst_pre: got %h want 55", led_out); end
        // Reset with a simultaneous write: reset must win
        rst = 1'b1;
        wr(2'd0, 32'hFFFF_FFFF);
        rst = 1'b0;
        n_checks++;
        if (led_out !== 8'hAA) begin n_fail++; $display("FAIL midrst_led: got %h want AA", led_out); end
        n_checks++;
        if (gpio_out !== 22'h0 || counter_set !== 2'b00) begin
            n_fail++; $display("FAIL midrst_ctrl: got %h/%h want 0/0", gpio_out, counter_set);
        end
        rd(2'd2, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL midrst_rd2: got %h want 0", r); end
        rd(2'd3, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL midrst_rd3: got %h want 0", r); end
        idle(6);
        n_checks++;
        if (led_out !== 8'hAA) begin n_fail++; $display("FAIL midrst_hold: got %h want AA", led_out); end
    endtask

    initial begin
        rst       = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 32'h0;
        test_reset();
        test_ctrl();
        test_set_clr();
        test_blink();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
